// File: rtl/lut_sweep_pkg.sv
// Shared types and width helpers for the truth-table evaluator and its sweep engine.
package lut_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sweep_state_e;

    function automatic int unsigned depth_of(input int unsigned n_in);
        return 32'd1 << n_in;
    endfunction

    // One extra bit so an all-ones table counts to DEPTH without wrapping.
    function automatic int unsigned ones_w(input int unsigned n_in);
        return n_in + 32'd1;
    endfunction

endpackage

// File: rtl/lut_sweep_fsm.sv
// Sweep sequencer: walks idx over every truth-table entry and flags busy/done.
module lut_sweep_fsm
    import lut_sweep_pkg::*;
#(
    parameter int unsigned N_IN = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            sweep_start,
    output logic            run_en,
    output logic            clr,
    output logic [N_IN-1:0] idx,
    output logic            sweep_busy,
    output logic            sweep_done
);

    localparam logic [N_IN-1:0] LAST = '1;

    sweep_state_e    state_q, state_d;
    logic [N_IN-1:0] idx_q, idx_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sweep_start) begin
                    state_d = RUN;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign run_en     = (state_q == RUN);
    assign clr        = (state_q == IDLE) && sweep_start;
    assign idx        = idx_q;
    assign sweep_busy = busy_q;
    assign sweep_done = done_q;

endmodule

// File: rtl/lut_sweep.sv
// Loadable N-input truth table with a 1-cycle evaluation pipe and an exhaustive readback sweep.
module lut_sweep
    import lut_sweep_pkg::*;
#(
    parameter int unsigned                N_IN = 4,
    parameter logic [depth_of(N_IN)-1:0]  INIT = 16'hAC3C
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cfg_we,
    input  logic [depth_of(N_IN)-1:0]   cfg_data,
    input  logic                        in_vld,
    input  logic [N_IN-1:0]             in_data,
    output logic                        out_vld,
    output logic                        out_bit,
    input  logic                        sweep_start,
    output logic                        sweep_busy,
    output logic                        sweep_done,
    output logic [depth_of(N_IN)-1:0]   sweep_img,
    output logic [ones_w(N_IN)-1:0]     sweep_ones
);

    localparam int unsigned DEPTH = depth_of(N_IN);
    localparam int unsigned OW    = ones_w(N_IN);

    logic             run_en;
    logic             clr;
    logic [N_IN-1:0]  idx;

    logic [DEPTH-1:0] table_q, table_d;
    logic             out_vld_q, out_vld_d;
    logic             out_bit_q, out_bit_d;
    logic [DEPTH-1:0] img_q, img_d;
    logic [OW-1:0]    ones_q, ones_d;

    lut_sweep_fsm #(
        .N_IN (N_IN)
    ) u_fsm (
        .clk         (clk),
        .rst_n       (rst_n),
        .sweep_start (sweep_start),
        .run_en      (run_en),
        .clr         (clr),
        .idx         (idx),
        .sweep_busy  (sweep_busy),
        .sweep_done  (sweep_done)
    );

    // Evaluation reads table_q, so a same-edge load only affects later requests.
    always_comb begin
        table_d   = table_q;
        out_vld_d = in_vld;
        out_bit_d = out_bit_q;
        img_d     = img_q;
        ones_d    = ones_q;

        if (cfg_we && !run_en) begin
            table_d = cfg_data;
        end
        if (in_vld) begin
            out_bit_d = table_q[in_data];
        end
        if (clr) begin
            img_d  = '0;
            ones_d = '0;
        end else if (run_en) begin
            img_d[idx] = table_q[idx];
            ones_d     = ones_q + {{(OW-1){1'b0}}, table_q[idx]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            table_q   <= INIT;
            out_vld_q <= 1'b0;
            out_bit_q <= 1'b0;
            img_q     <= '0;
            ones_q    <= '0;
        end else begin
            table_q   <= table_d;
            out_vld_q <= out_vld_d;
            out_bit_q <= out_bit_d;
            img_q     <= img_d;
            ones_q    <= ones_d;
        end
    end

    assign out_vld    = out_vld_q;
    assign out_bit    = out_bit_q;
    assign sweep_img  = img_q;
    assign sweep_ones = ones_q;

endmodule
